// File: rtl/daq_pkg.sv
// Shared DAQ definitions: word width, CRC defaults, checker state encoding and
// the per-word CRC step used by both the transmit generator and this checker.
package daq_pkg;

  localparam int unsigned DAQ_W  = 16;
  localparam int unsigned WCNT_W = 11;

  localparam logic [DAQ_W-1:0] CRC_POLY_DEF = 16'h1021;
  localparam logic [DAQ_W-1:0] CRC_INIT_DEF = 16'hFFFF;

  typedef enum logic {
    IDLE,
    ACCUM
  } daq_state_e;

  // Word-wide fold: 16 serial MSB-first steps of (crc ^ d); no reflection, no final XOR.
  function automatic logic [DAQ_W-1:0] crc16_step(input logic [DAQ_W-1:0] crc,
                                                  input logic [DAQ_W-1:0] d,
                                                  input logic [DAQ_W-1:0] poly);
    logic [DAQ_W-1:0] c;
    c = crc ^ d;
    for (int unsigned i = 0; i < DAQ_W; i++) begin
      c = c[DAQ_W-1] ? ((c << 1) ^ poly) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/daq_crc_check_if.sv
// DAQ receive word stream: data word plus its valid, start-of-frame and
// CRC-word qualifiers.
interface daq_crc_check_if;
  import daq_pkg::*;

  logic [DAQ_W-1:0] d;
  logic             d_valid;
  logic             sof;
  logic             crc_word;

  modport master (output d, d_valid, sof, crc_word);
  modport slave  (input  d, d_valid, sof, crc_word);
endinterface

// File: rtl/daq_crc_core.sv
// Registered CRC accumulator: init_i reloads INIT, calc_i folds d_i in;
// both together start a new frame with d_i as its first word.
module daq_crc_core
  import daq_pkg::*;
#(
  parameter logic [DAQ_W-1:0] POLY = CRC_POLY_DEF,
  parameter logic [DAQ_W-1:0] INIT = CRC_INIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init_i,
  input  logic             calc_i,
  input  logic [DAQ_W-1:0] d_i,
  output logic [DAQ_W-1:0] crc_o
);

  logic [DAQ_W-1:0] crc_q, crc_d, base;

  always_comb begin
    base  = init_i ? INIT : crc_q;
    crc_d = crc_q;
    if (calc_i) begin
      crc_d = crc16_step(base, d_i, POLY);
    end else if (init_i) begin
      crc_d = INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/daq_crc_check.sv
// Receive-side DAQ CRC checker: per-frame verdict, length and saturating error count.
// Define DAQ_CRC_STATS_EN to add frame_cnt and last_bad_len outputs.
module daq_crc_check
  import daq_pkg::*;
#(
  parameter logic [DAQ_W-1:0] CRC_POLY  = CRC_POLY_DEF,
  parameter logic [DAQ_W-1:0] CRC_INIT  = CRC_INIT_DEF,
  parameter int unsigned      MAX_WORDS = 1024,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  daq_crc_check_if.slave    rx,
  input  logic              clr_cnt,
  output logic              frame_done,
  output logic              crc_ok,
  output logic              crc_err,
  output logic [DAQ_W-1:0]  calc_crc,
  output logic [DAQ_W-1:0]  rx_crc,
  output logic [WCNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0]  err_cnt
`ifdef DAQ_CRC_STATS_EN
  ,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [10:0]       last_bad_len
`endif
);

  localparam logic [WCNT_W-1:0] MAX_CNT = WCNT_W'(MAX_WORDS);

  daq_state_e        state_q, state_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d, wcnt_q, wcnt_d;
  logic              done_q, done_d, ok_q, ok_d, err_q, err_d;
  logic [DAQ_W-1:0]  calc_q, calc_d, rxc_q, rxc_d, crc;
  logic [CNT_W-1:0]  errc_q, errc_d;
  logic              core_init, core_calc;

  daq_crc_core #(
    .POLY (CRC_POLY),
    .INIT (CRC_INIT)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .init_i (core_init),
    .calc_i (core_calc),
    .d_i    (rx.d),
    .crc_o  (crc)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wcnt_d    = wcnt_q;
    calc_d    = calc_q;
    rxc_d     = rxc_q;
    done_d    = 1'b0;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    core_init = 1'b0;
    core_calc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx.d_valid && rx.sof) begin
          core_init = 1'b1;
          core_calc = 1'b1;
          cnt_d     = WCNT_W'(1);
          state_d   = ACCUM;
        end
      end
      ACCUM: begin
        if (rx.d_valid) begin
          // sof wins over crc_word: the truncated frame fails and this word opens the next one.
          if (rx.sof) begin
            done_d    = 1'b1;
            err_d     = 1'b1;
            wcnt_d    = cnt_q;
            calc_d    = crc;
            core_init = 1'b1;
            core_calc = 1'b1;
            cnt_d     = WCNT_W'(1);
          end else if (rx.crc_word) begin
            done_d  = 1'b1;
            ok_d    = (crc == rx.d);
            err_d   = (crc != rx.d);
            wcnt_d  = cnt_q;
            calc_d  = crc;
            rxc_d   = rx.d;
            state_d = IDLE;
          end else if (cnt_q == MAX_CNT) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            wcnt_d  = cnt_q;
            calc_d  = crc;
            state_d = IDLE;
          end else begin
            core_calc = 1'b1;
            cnt_d     = cnt_q + WCNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    errc_d = errc_q;
    if (clr_cnt) begin
      errc_d = '0;
    end else if (err_d && (errc_q != '1)) begin
      errc_d = errc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      calc_q  <= '0;
      rxc_q   <= '0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      calc_q  <= calc_d;
      rxc_q   <= rxc_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      errc_q  <= errc_d;
    end
  end

  assign frame_done = done_q;
  assign crc_ok     = ok_q;
  assign crc_err    = err_q;
  assign calc_crc   = calc_q;
  assign rx_crc     = rxc_q;
  assign word_cnt   = wcnt_q;
  assign err_cnt    = errc_q;

`ifdef DAQ_CRC_STATS_EN
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [10:0]      badlen_q, badlen_d;

  always_comb begin
    fcnt_d   = fcnt_q;
    badlen_d = badlen_q;
    if (clr_cnt) begin
      fcnt_d = '0;
    end else if (done_d && (fcnt_q != '1)) begin
      fcnt_d = fcnt_q + 1'b1;
    end
    if (done_d && err_d) begin
      badlen_d = wcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt_q   <= '0;
      badlen_q <= '0;
    end else begin
      fcnt_q   <= fcnt_d;
      badlen_q <= badlen_d;
    end
  end

  assign frame_cnt    = fcnt_q;
  assign last_bad_len = badlen_q;
`endif

endmodule

// File: tb/tb_daq_crc_check.sv
// Directed bench for daq_crc_check: four instances (CRC_INIT=0, defaults,
// MAX_WORDS=4, CNT_W=2) observe one shared word stream.
`timescale 1ns/1ps
module tb_daq_crc_check;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clr_cnt = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #12 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  daq_crc_check_if bus ();

  logic        fd [4];
  logic        ok [4];
  logic        er [4];
  logic [15:0] cc [4];
  logic [15:0] rc [4];
  logic [10:0] wc [4];
  logic [15:0] ec [3];
  logic [1:0]  ec2;
`ifdef DAQ_CRC_STATS_EN
  logic [15:0] fcnt [3];
  logic [1:0]  fcnt2;
  logic [10:0] lbl [4];
`endif

  daq_crc_check #(.CRC_INIT(16'h0000)) u_init0 (
    .clk(clk), .reset(reset), .rx(bus), .clr_cnt(clr_cnt),
    .frame_done(fd[0]), .crc_ok(ok[0]), .crc_err(er[0]), .calc_crc(cc[0]),
    .rx_crc(rc[0]), .word_cnt(wc[0]), .err_cnt(ec[0])
`ifdef DAQ_CRC_STATS_EN
    , .frame_cnt(fcnt[0]), .last_bad_len(lbl[0])
`endif
  );

  daq_crc_check u_def (
    .clk(clk), .reset(reset), .rx(bus), .clr_cnt(clr_cnt),
    .frame_done(fd[1]), .crc_ok(ok[1]), .crc_err(er[1]), .calc_crc(cc[1]),
    .rx_crc(rc[1]), .word_cnt(wc[1]), .err_cnt(ec[1])
`ifdef DAQ_CRC_STATS_EN
    , .frame_cnt(fcnt[1]), .last_bad_len(lbl[1])
`endif
  );

  daq_crc_check #(.MAX_WORDS(4)) u_max4 (
    .clk(clk), .reset(reset), .rx(bus), .clr_cnt(clr_cnt),
    .frame_done(fd[2]), .crc_ok(ok[2]), .crc_err(er[2]), .calc_crc(cc[2]),
    .rx_crc(rc[2]), .word_cnt(wc[2]), .err_cnt(ec[2])
`ifdef DAQ_CRC_STATS_EN
    , .frame_cnt(fcnt[2]), .last_bad_len(lbl[2])
`endif
  );

  daq_crc_check #(.CNT_W(2)) u_cnt2 (
    .clk(clk), .reset(reset), .rx(bus), .clr_cnt(clr_cnt),
    .frame_done(fd[3]), .crc_ok(ok[3]), .crc_err(er[3]), .calc_crc(cc[3]),
    .rx_crc(rc[3]), .word_cnt(wc[3]), .err_cnt(ec2)
`ifdef DAQ_CRC_STATS_EN
    , .frame_cnt(fcnt2), .last_bad_len(lbl[3])
`endif
  );

  // Reference CRC, bit-at-a-time formulation: feedback = crc MSB xor data bit.
  function automatic logic [15:0] mdl(input logic [15:0] c, input logic [15:0] w);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int b = 15; b >= 0; b--) begin
      fb = r[15] ^ w[b];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  // Drive one cycle of inputs at a falling edge, then advance to the next falling edge.
  task automatic cyc(input logic v, input logic [15:0] w, input logic s, input logic c);
    bus.d_valid  = v;
    bus.d        = w;
    bus.sof      = s;
    bus.crc_word = c;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  logic [15:0] w [32];
  logic [15:0] crc;
  logic [15:0] bad;
  int          extra;

  initial begin
    bus.d_valid = 1'b0; bus.d = 16'h0000; bus.sof = 1'b0; bus.crc_word = 1'b0;
    w[0] = 16'h9001; w[1] = 16'h9000; w[2] = 16'h907F; w[3] = 16'h9000; w[4] = 16'hA07F;
    for (int i = 5; i < 31; i++) w[i] = 16'hA07F + 16'(i * 291);
    w[31] = 16'hEA3F;

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_done", fd[1], 1'b0);
    chk("rst_ok", ok[1], 1'b0);
    chk("rst_err", er[1], 1'b0);
    chk("rst_calc", cc[1], 16'h0000);
    chk("rst_rx", rc[1], 16'h0000);
    chk("rst_wcnt", wc[1], 11'd0);
    chk("rst_ecnt", ec[1], 16'h0000);

    // 1: CRC_INIT=0, single word 0001 gives 1021
    cyc(1'b1, 16'h0001, 1'b1, 1'b0);
    cyc(1'b1, 16'h1021, 1'b0, 1'b1);
    chk("t1_done", fd[0], 1'b1);
    chk("t1_ok", ok[0], 1'b1);
    chk("t1_err", er[0], 1'b0);
    chk("t1_calc", cc[0], 16'h1021);
    chk("t1_rx", rc[0], 16'h1021);
    chk("t1_wcnt", wc[0], 11'd1);
    idle(1);
    chk("t1_pulse", fd[0], 1'b0);

    // 2: eight zero words, good then bad CRC word
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'h0000, 1'(i == 0), 1'b0);
    cyc(1'b1, 16'h0000, 1'b0, 1'b1);
    chk("t2_ok", ok[0], 1'b1);
    chk("t2_wcnt", wc[0], 11'd8);
    chk("t2_ecnt0", ec[0], 16'h0000);
    idle(2);
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'h0000, 1'(i == 0), 1'b0);
    cyc(1'b1, 16'h0001, 1'b0, 1'b1);
    chk("t2_err", er[0], 1'b1);
    chk("t2_nok", ok[0], 1'b0);
    idle(1);
    chk("t2_ecnt1", ec[0], 16'h0001);

    // 3: 32-word stream with 3-cycle gaps, then bit 0 of word 5 flipped
    crc = 16'hFFFF;
    for (int i = 0; i < 32; i++) crc = mdl(crc, w[i]);
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, w[i], 1'(i == 0), 1'b0);
      idle(3);
    end
    cyc(1'b1, crc, 1'b0, 1'b1);
    chk("t3_done", fd[1], 1'b1);
    chk("t3_ok", ok[1], 1'b1);
    chk("t3_calc", cc[1], crc);
    chk("t3_wcnt", wc[1], 11'd32);
    idle(2);
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, w[i] ^ {15'd0, (i == 5)}, 1'(i == 0), 1'b0);
      idle(3);
    end
    cyc(1'b1, crc, 1'b0, 1'b1);
    chk("t3_flip_err", er[1], 1'b1);
    chk("t3_flip_ok", ok[1], 1'b0);
    idle(2);

    // 4: sof after 4 words aborts, the new frame then checks normally
    for (int i = 0; i < 4; i++) cyc(1'b1, w[i], 1'(i == 0), 1'b0);
    cyc(1'b1, w[4], 1'b1, 1'b0);
    chk("t4_abort_done", fd[1], 1'b1);
    chk("t4_abort_err", er[1], 1'b1);
    chk("t4_abort_ok", ok[1], 1'b0);
    chk("t4_abort_wcnt", wc[1], 11'd4);
    crc = mdl(16'hFFFF, w[4]);
    for (int i = 5; i < 10; i++) begin
      cyc(1'b1, w[i], 1'b0, 1'b0);
      crc = mdl(crc, w[i]);
    end
    cyc(1'b1, crc, 1'b0, 1'b1);
    chk("t4_next_ok", ok[1], 1'b1);
    chk("t4_next_wcnt", wc[1], 11'd6);
    idle(2);

    // 5: MAX_WORDS=4, overlength on the 5th word, rest ignored
    for (int i = 0; i < 5; i++) cyc(1'b1, w[i], 1'(i == 0), 1'b0);
    chk("t5_done", fd[2], 1'b1);
    chk("t5_err", er[2], 1'b1);
    chk("t5_wcnt", wc[2], 11'd4);
    extra = 0;
    cyc(1'b1, w[5], 1'b0, 1'b0); extra += int'(fd[2]);
    cyc(1'b1, 16'h1234, 1'b0, 1'b1); extra += int'(fd[2]);
    idle(1); extra += int'(fd[2]);
    idle(1); extra += int'(fd[2]);
    chk("t5_no_second", extra, 0);

    // 6: counter clear, clear priority, saturation
    clr_cnt = 1'b1; idle(1); clr_cnt = 1'b0;
    chk("t6_clr_def", ec[1], 16'h0000);
    chk("t6_clr_c2", ec2, 2'd0);
    bad = ~mdl(16'hFFFF, w[0]);
    cyc(1'b1, w[0], 1'b1, 1'b0);
    clr_cnt = 1'b1;
    cyc(1'b1, bad, 1'b0, 1'b1);
    clr_cnt = 1'b0;
    chk("t6_prio_err", er[1], 1'b1);
    chk("t6_prio_cnt", ec2, 2'd0);
    for (int f = 1; f <= 4; f++) begin
      cyc(1'b1, w[0], 1'b1, 1'b0);
      cyc(1'b1, bad, 1'b0, 1'b1);
      chk("t6_sat_c2", ec2, (f < 3) ? 2'(f) : 2'd3);
    end
    chk("t6_def_cnt", ec[1], 16'd4);
`ifdef DAQ_CRC_STATS_EN
    chk("t6_fcnt_def", fcnt[1], 16'd4);
    chk("t6_fcnt_sat", fcnt2, 2'd3);
    chk("t6_badlen", lbl[1], 11'd1);
`endif
    clr_cnt = 1'b1; idle(1); clr_cnt = 1'b0;
    chk("t6_reclr_c2", ec2, 2'd0);
    chk("t6_reclr_def", ec[1], 16'h0000);
`ifdef DAQ_CRC_STATS_EN
    chk("t6_reclr_fcnt", fcnt[1], 16'h0000);
`endif

    // Reset mid-frame: no verdict, following CRC word ignored, next frame clean
    cyc(1'b1, w[0], 1'b1, 1'b0);
    cyc(1'b1, w[1], 1'b0, 1'b0);
    reset = 1'b1; idle(1); reset = 1'b0;
    chk("rst_mid_done", fd[1], 1'b0);
    chk("rst_mid_wcnt", wc[1], 11'd0);
    cyc(1'b1, mdl(mdl(16'hFFFF, w[0]), w[1]), 1'b0, 1'b1);
    chk("rst_mid_ign", fd[1], 1'b0);
    cyc(1'b1, w[2], 1'b1, 1'b0);
    cyc(1'b1, mdl(16'hFFFF, w[2]), 1'b0, 1'b1);
    chk("rst_mid_next", ok[1], 1'b1);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
